// File: rtl/audio_pkg.sv
// Shared types for the audio sample feeder.
//   SAMPLE_WIDTH : default bits per channel sample
//   feed_state_t : FILL (pre-filling / silent) or RUN (playing)
//   channel_t    : LEFT / RIGHT slot of the next transmitter request
//   frame_t      : one stereo frame {l, r} as stored in the FIFO
package audio_pkg;

    localparam int unsigned SAMPLE_WIDTH = 16;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } feed_state_t;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } channel_t;

    typedef struct packed {
        logic [SAMPLE_WIDTH-1:0] l;
        logic [SAMPLE_WIDTH-1:0] r;
    } frame_t;

endpackage

// File: rtl/audio_sample_feeder_if.sv
// Producer / transmitter side bus of the audio sample feeder.
//   master : sound generator + I2S transmitter (drive frames, REQ, UNDERRUN_CLR)
//   slave  : the feeder (returns IN_READY, SAMPLE_OUT, LEVEL, PLAYING, UNDERRUN)
interface audio_sample_feeder_if #(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH   = 8
);
    logic [SAMPLE_WIDTH-1:0]       IN_L;
    logic [SAMPLE_WIDTH-1:0]       IN_R;
    logic                          IN_VALID;
    logic                          IN_READY;
    logic                          REQ;
    logic [SAMPLE_WIDTH-1:0]       SAMPLE_OUT;
    logic [$clog2(FIFO_DEPTH):0]   LEVEL;
    logic                          PLAYING;
    logic                          UNDERRUN;
    logic                          UNDERRUN_CLR;

    modport master (
        output IN_L, IN_R, IN_VALID, REQ, UNDERRUN_CLR,
        input  IN_READY, SAMPLE_OUT, LEVEL, PLAYING, UNDERRUN
    );

    modport slave (
        input  IN_L, IN_R, IN_VALID, REQ, UNDERRUN_CLR,
        output IN_READY, SAMPLE_OUT, LEVEL, PLAYING, UNDERRUN
    );
endinterface

// File: rtl/audio_frame_fifo.sv
// Synchronous stereo-frame FIFO with first-word fall-through read data.
//   clk, rst_n : clock, async active-low reset
//   wr_i       : write wdata_i (ignored when full)
//   rd_i       : pop head frame (ignored when empty)
//   rdata_c    : head frame, valid while !empty_c
//   full_c     : FIFO_DEPTH frames stored
//   empty_c    : no frame stored
//   level_o    : registered frame count, 0..FIFO_DEPTH
module audio_frame_fifo
    import audio_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_i,
    input  logic                        rd_i,
    input  frame_t                      wdata_i,
    output frame_t                      rdata_c,
    output logic                        full_c,
    output logic                        empty_c,
    output logic [$clog2(FIFO_DEPTH):0] level_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    frame_t          mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            wr_en;
    logic            rd_en;

    assign full_c  = (count_q == CW'(FIFO_DEPTH));
    assign empty_c = (count_q == '0);
    assign wr_en   = wr_i && !full_c;
    assign rd_en   = rd_i && !empty_c;
    assign rdata_c = mem_q[rd_ptr_q];
    assign level_o = count_q;

    // Storage; pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/audio_sample_feeder.sv
// Audio sample feeder: buffers stereo frames and answers each transmitter
// REQ rising edge with the next sample, alternating LEFT then RIGHT.
// Playback starts (and restarts after underrun) only once START_LEVEL frames
// are buffered, and state changes only on LEFT events so frames never split.
// Optional macro AUDIO_FEED_HOLD_EN: while silent after something has played,
// repeat the last played L/R instead of outputting 0.
//   CLK_DAC : bit clock shared with the transmitter
//   RESET_n : async active-low reset
//   bus     : slave side of audio_sample_feeder_if (frames in, REQ, samples out,
//             LEVEL, PLAYING, sticky UNDERRUN with UNDERRUN_CLR)
// SAMPLE_WIDTH must equal audio_pkg::SAMPLE_WIDTH since frame_t lives there.
module audio_sample_feeder #(
    parameter int unsigned SAMPLE_WIDTH = audio_pkg::SAMPLE_WIDTH,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned START_LEVEL  = 4
) (
    input  logic                  CLK_DAC,
    input  logic                  RESET_n,
    audio_sample_feeder_if.slave  bus
);

    import audio_pkg::*;

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    feed_state_t              state_q, state_d;
    channel_t                 phase_q, phase_d;
    logic                     req_prev_q;
    logic [SAMPLE_WIDTH-1:0]  sample_q, sample_d;
    logic [SAMPLE_WIDTH-1:0]  hold_r_q, hold_r_d;
    logic                     underrun_q, underrun_d;
    logic                     playing_q;
    logic                     ready_q, ready_d;

    logic                     req_evt_c;
    logic                     pop_c;
    logic                     push_c;
    logic [LW-1:0]            level;
    logic [LW-1:0]            level_nxt_c;
    logic [SAMPLE_WIDTH-1:0]  silence_l_c;
    logic [SAMPLE_WIDTH-1:0]  silence_r_c;
    frame_t                   head_c;
    frame_t                   wframe_c;
    logic                     full_c;
    logic                     empty_c;

    assign wframe_c.l = bus.IN_L;
    assign wframe_c.r = bus.IN_R;
    assign push_c     = bus.IN_VALID && ready_q && !full_c;
    assign req_evt_c  = bus.REQ && !req_prev_q;

    audio_frame_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK_DAC),
        .rst_n   (RESET_n),
        .wr_i    (push_c),
        .rd_i    (pop_c),
        .wdata_i (wframe_c),
        .rdata_c (head_c),
        .full_c  (full_c),
        .empty_c (empty_c),
        .level_o (level)
    );

`ifdef AUDIO_FEED_HOLD_EN
    // Last popped frame; stays 0 until the first frame has played.
    logic [SAMPLE_WIDTH-1:0] last_l_q;
    logic [SAMPLE_WIDTH-1:0] last_r_q;

    always_ff @(posedge CLK_DAC or negedge RESET_n) begin
        if (!RESET_n) begin
            last_l_q <= '0;
            last_r_q <= '0;
        end else if (pop_c) begin
            last_l_q <= SAMPLE_WIDTH'(head_c.l);
            last_r_q <= SAMPLE_WIDTH'(head_c.r);
        end
    end

    assign silence_l_c = last_l_q;
    assign silence_r_c = last_r_q;
`else
    assign silence_l_c = '0;
    assign silence_r_c = '0;
`endif

    // State and output registers.
    always_ff @(posedge CLK_DAC or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q    <= FILL;
            phase_q    <= LEFT;
            req_prev_q <= 1'b0;
            sample_q   <= '0;
            hold_r_q   <= '0;
            underrun_q <= 1'b0;
            playing_q  <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            req_prev_q <= bus.REQ;
            sample_q   <= sample_d;
            hold_r_q   <= hold_r_d;
            underrun_q <= underrun_d;
            playing_q  <= (state_d == RUN);
            ready_q    <= ready_d;
        end
    end

    // Next state: LEFT events decide play/fill/underrun, RIGHT events replay held R.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        sample_d   = sample_q;
        hold_r_d   = hold_r_q;
        underrun_d = underrun_q && !bus.UNDERRUN_CLR;
        pop_c      = 1'b0;

        if (req_evt_c) begin
            phase_d = (phase_q == LEFT) ? RIGHT : LEFT;
            if (phase_q == RIGHT) begin
                sample_d = hold_r_q;
            end else begin
                sample_d = silence_l_c;
                hold_r_d = silence_r_c;
                case (state_q)
                    RUN: begin
                        if (!empty_c) begin
                            pop_c = 1'b1;
                        end else begin
                            state_d    = FILL;
                            underrun_d = 1'b1;
                        end
                    end
                    FILL: begin
                        if (level >= LW'(START_LEVEL)) begin
                            state_d = RUN;
                            pop_c   = 1'b1;
                        end
                    end
                endcase
                if (pop_c) begin
                    sample_d = SAMPLE_WIDTH'(head_c.l);
                    hold_r_d = SAMPLE_WIDTH'(head_c.r);
                end
            end
        end

        // Ready reflects the count after this cycle's write/pop, so no write is taken while full.
        level_nxt_c = level + LW'(push_c) - LW'(pop_c);
        ready_d     = (level_nxt_c != LW'(FIFO_DEPTH));
    end

    assign bus.IN_READY   = ready_q;
    assign bus.SAMPLE_OUT = sample_q;
    assign bus.LEVEL      = level;
    assign bus.PLAYING    = playing_q;
    assign bus.UNDERRUN   = underrun_q;

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Directed bench for audio_sample_feeder: reset, pre-fill, playback order,
// underrun, full FIFO with simultaneous pop/write, held REQ, mid-frame reset.
module tb_audio_sample_feeder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int unsigned passed = 0;
    int unsigned failed = 0;
    int unsigned total  = 0;

`ifdef AUDIO_FEED_HOLD_EN
    localparam logic [15:0] UL = 16'h1003;
    localparam logic [15:0] UR = 16'h2003;
`else
    localparam logic [15:0] UL = 16'h0000;
    localparam logic [15:0] UR = 16'h0000;
`endif

    audio_sample_feeder_if #(.SAMPLE_WIDTH(16), .FIFO_DEPTH(8)) bus ();

    audio_sample_feeder #(
        .SAMPLE_WIDTH (16),
        .FIFO_DEPTH   (8),
        .START_LEVEL  (4)
    ) dut (
        .CLK_DAC (clk),
        .RESET_n (rst_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},    32'(bus.IN_READY),   32'd0);
        check({tag, "_sample"},   32'(bus.SAMPLE_OUT), 32'd0);
        check({tag, "_level"},    32'(bus.LEVEL),      32'd0);
        check({tag, "_playing"},  32'(bus.PLAYING),    32'd0);
        check({tag, "_underrun"}, 32'(bus.UNDERRUN),   32'd0);
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.IN_READY && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("push_ready_timeout", 32'(bus.IN_READY), 32'd1);
        bus.IN_VALID = 1'b1;
        bus.IN_L     = l;
        bus.IN_R     = r;
        @(negedge clk);
        bus.IN_VALID = 1'b0;
    endtask

    // REQ launched on negedge, held 'hold' cycles; checked once it drops.
    task automatic req(input int hold, input logic [15:0] exp, input string tag);
        repeat (15) @(negedge clk);
        bus.REQ = 1'b1;
        repeat (hold) @(negedge clk);
        bus.REQ = 1'b0;
        check(tag, 32'(bus.SAMPLE_OUT), 32'(exp));
    endtask

    initial begin
        int k;
        rst_n            = 1'b0;
        bus.IN_L         = '0;
        bus.IN_R         = '0;
        bus.IN_VALID     = 1'b0;
        bus.REQ          = 1'b0;
        bus.UNDERRUN_CLR = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_after", 32'(bus.IN_READY), 32'd1);

        // Below START_LEVEL: silence, not playing.
        for (int i = 0; i < 3; i++) push(16'(16'h1000 + i), 16'(16'h2000 + i));
        check("fill_level3", 32'(bus.LEVEL), 32'd3);
        for (int i = 0; i < 4; i++) req(1, 16'h0000, "fill_silent");
        check("fill_playing", 32'(bus.PLAYING), 32'd0);
        check("fill_level_kept", 32'(bus.LEVEL), 32'd3);

        // Fourth frame arrives: next LEFT event starts playback.
        push(16'h1003, 16'h2003);
        check("fill_level4", 32'(bus.LEVEL), 32'd4);
        req(1, 16'h1000, "run_l0");
        check("run_playing", 32'(bus.PLAYING), 32'd1);
        check("run_level3", 32'(bus.LEVEL), 32'd3);
        req(1, 16'h2000, "run_r0");
        for (int i = 1; i < 4; i++) begin
            req(1, 16'(16'h1000 + i), "run_l");
            req(1, 16'(16'h2000 + i), "run_r");
        end
        check("run_level0", 32'(bus.LEVEL), 32'd0);
        check("run_no_underrun", 32'(bus.UNDERRUN), 32'd0);

        // Starve with UNDERRUN_CLR asserted on the same cycle: set wins.
        repeat (15) @(negedge clk);
        bus.REQ          = 1'b1;
        bus.UNDERRUN_CLR = 1'b1;
        @(negedge clk);
        bus.REQ          = 1'b0;
        bus.UNDERRUN_CLR = 1'b0;
        check("udr_l", 32'(bus.SAMPLE_OUT), 32'(UL));
        check("udr_flag", 32'(bus.UNDERRUN), 32'd1);
        check("udr_playing", 32'(bus.PLAYING), 32'd0);
        req(1, UR, "udr_r");
        check("udr_sticky", 32'(bus.UNDERRUN), 32'd1);
        @(negedge clk);
        bus.UNDERRUN_CLR = 1'b1;
        @(negedge clk);
        bus.UNDERRUN_CLR = 1'b0;
        check("udr_clr", 32'(bus.UNDERRUN), 32'd0);

        // Hold IN_VALID high with no REQ until the FIFO fills.
        k = 0;
        bus.IN_VALID = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (bus.IN_READY) begin
                bus.IN_L = 16'(16'h3000 + k);
                bus.IN_R = 16'(16'h4000 + k);
                k++;
            end
            @(negedge clk);
        end
        bus.IN_L = 16'h3008;
        bus.IN_R = 16'h4008;
        check("full_accepted", 32'(k), 32'd8);
        check("full_level", 32'(bus.LEVEL), 32'd8);
        check("full_ready", 32'(bus.IN_READY), 32'd0);

        // LEFT event while full with IN_VALID still high: pop now, write next cycle.
        bus.REQ = 1'b1;
        @(negedge clk);
        bus.REQ = 1'b0;
        check("full_pop_sample", 32'(bus.SAMPLE_OUT), 32'h3000);
        check("full_pop_level", 32'(bus.LEVEL), 32'd7);
        check("full_pop_ready", 32'(bus.IN_READY), 32'd1);
        check("full_pop_playing", 32'(bus.PLAYING), 32'd1);
        @(negedge clk);
        bus.IN_VALID = 1'b0;
        check("refill_level", 32'(bus.LEVEL), 32'd8);
        check("refill_ready", 32'(bus.IN_READY), 32'd0);
        req(1, 16'h4000, "full_r0");

        // REQ held three cycles: one pop, one toggle.
        req(3, 16'h3001, "held_l");
        check("held_level", 32'(bus.LEVEL), 32'd7);
        req(1, 16'h4001, "held_r");

        // Pop and write in the same cycle: level unchanged.
        repeat (15) @(negedge clk);
        bus.REQ      = 1'b1;
        bus.IN_VALID = 1'b1;
        bus.IN_L     = 16'h3009;
        bus.IN_R     = 16'h4009;
        @(negedge clk);
        bus.REQ      = 1'b0;
        bus.IN_VALID = 1'b0;
        check("both_sample", 32'(bus.SAMPLE_OUT), 32'h3002);
        check("both_level", 32'(bus.LEVEL), 32'd7);

        // Reset between LEFT and RIGHT.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) push(16'(16'h5000 + i), 16'(16'h6000 + i));
        req(1, 16'h5000, "post_rst_l");
        check("post_rst_playing", 32'(bus.PLAYING), 32'd1);
        req(1, 16'h6000, "post_rst_r");
        check("post_rst_level", 32'(bus.LEVEL), 32'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
